// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: full-precision |X|^2 per FFT bin with bin tagging,
// per-frame peak search over an eligible bin range, framing check and
// good-frame counter. Two-stage magnitude pipeline, peak result one cycle
// after the last magnitude of a good frame.
module fft_peak_tracker #(
    parameter int DW        = 12,
    parameter int N_LOG2    = 10,
    parameter int MIN_BIN   = 1,
    parameter int HALF_SPEC = 1,
    parameter int FCNT_W    = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 src_valid,
    input  logic                 src_sop,
    input  logic                 src_eop,
    input  logic signed [DW-1:0] src_real,
    input  logic signed [DW-1:0] src_imag,
    output logic                 amp_valid,
    output logic [2*DW-1:0]      amp_data,
    output logic [N_LOG2-1:0]    amp_bin,
    output logic                 peak_valid,
    output logic [N_LOG2-1:0]    peak_bin,
    output logic [2*DW-1:0]      peak_amp,
    output logic                 frame_err,
    output logic [FCNT_W-1:0]    frame_cnt
);

    localparam int AW = 2 * DW;
    localparam logic [N_LOG2-1:0] LAST_BIN = '1;
    localparam logic [N_LOG2-1:0] LO_BIN   = N_LOG2'(MIN_BIN);
    localparam logic [N_LOG2-1:0] HI_BIN   = (HALF_SPEC != 0) ? (LAST_BIN >> 1) : LAST_BIN;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] bin_q, bin_d;

    // Decode of the current input beat
    logic              beat_emit;   // beat enters the magnitude pipeline
    logic              beat_first;  // beat opens a frame (restarts the running max)
    logic              beat_good;   // beat is the eop of a correctly framed frame
    logic              beat_err;    // beat reveals a framing error
    logic [N_LOG2-1:0] beat_bin;

    // Stage 1: squared components
    logic              s1_valid, s1_first, s1_good;
    logic [AW-1:0]     s1_rr, s1_ii;
    logic [N_LOG2-1:0] s1_bin;

    // Stage 2 side flags travelling alongside amp_*
    logic              s2_first, s2_good;

    // Running peak of the frame in progress
    logic [AW-1:0]     run_amp, base_amp, nxt_amp;
    logic [N_LOG2-1:0] run_bin, base_bin, nxt_bin;
    logic              amp_eligible;

    // Operands widened with sign so the products keep full precision
    logic signed [AW-1:0] re_x, im_x;
    assign re_x = AW'(src_real);
    assign im_x = AW'(src_imag);

    // Framing FSM: next state, bin counter and beat classification
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        bin_d      = bin_q;
        beat_emit  = 1'b0;
        beat_first = 1'b0;
        beat_good  = 1'b0;
        beat_err   = 1'b0;
        beat_bin   = bin_q;
        if (src_valid) begin
            if (src_sop) begin
                // sop always (re)starts a frame; an open frame is aborted
                beat_emit  = 1'b1;
                beat_first = 1'b1;
                beat_bin   = '0;
                beat_err   = (state_q == FRAME);
                if (src_eop) begin
                    // single-beat frame can never be complete
                    beat_err = 1'b1;
                    state_d  = IDLE;
                    bin_d    = '0;
                end else begin
                    state_d = FRAME;
                    bin_d   = N_LOG2'(1);
                end
            end else if (state_q == FRAME) begin
                beat_emit = 1'b1;
                if (src_eop) begin
                    state_d = IDLE;
                    bin_d   = '0;
                    if (bin_q == LAST_BIN) beat_good = 1'b1;
                    else                   beat_err  = 1'b1;
                end else if (bin_q == LAST_BIN) begin
                    // frame ran to full length without eop
                    beat_err = 1'b1;
                    state_d  = IDLE;
                    bin_d    = '0;
                end else begin
                    bin_d = bin_q + N_LOG2'(1);
                end
            end
            // IDLE beat without sop: dropped silently
        end
    end

    // FSM state, bin counter and framing-error pulse
    always_ff @(posedge sys_clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (sys_rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            frame_err <= beat_err;
        end
    end

    // Stage 1: register re^2 and im^2 with the beat's tags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_good  <= 1'b0;
            s1_rr    <= '0;
            s1_ii    <= '0;
            s1_bin   <= '0;
        end else begin
            s1_valid <= beat_emit;
            s1_first <= beat_emit & beat_first;
            s1_good  <= beat_emit & beat_good;
            if (beat_emit) begin
                s1_rr  <= re_x * re_x;
                s1_ii  <= im_x * im_x;
                s1_bin <= beat_bin;
            end
        end
    end

    // Stage 2: sum of squares; both terms are non-negative and the sum fits AW bits
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            amp_valid <= 1'b0;
            amp_data  <= '0;
            amp_bin   <= '0;
            s2_first  <= 1'b0;
            s2_good   <= 1'b0;
        end else begin
            amp_valid <= s1_valid;
            s2_first  <= s1_valid & s1_first;
            s2_good   <= s1_valid & s1_good;
            if (s1_valid) begin
                amp_data <= s1_rr + s1_ii;
                amp_bin  <= s1_bin;
            end
        end
    end

    assign amp_eligible = (amp_bin >= LO_BIN) && (amp_bin <= HI_BIN);

    // Peak candidate: start afresh on a frame's first bin, strict compare keeps the lowest bin on ties
    always_comb begin
        base_amp = run_amp;
        base_bin = run_bin;
        if (s2_first) begin
            base_amp = '0;
            base_bin = LO_BIN;
        end
        nxt_amp = base_amp;
        nxt_bin = base_bin;
        if (amp_valid && amp_eligible && (amp_data > base_amp)) begin
            nxt_amp = amp_data;
            nxt_bin = amp_bin;
        end
    end

    // Running max, published peak and good-frame counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            run_amp    <= '0;
            run_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_amp   <= '0;
            frame_cnt  <= '0;
        end else begin
            peak_valid <= s2_good;
            if (amp_valid) begin
                run_amp <= nxt_amp;
                run_bin <= nxt_bin;
            end
            if (s2_good) begin
                peak_amp  <= nxt_amp;
                peak_bin  <= nxt_bin;
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Scoreboard bench for fft_peak_tracker (DW=12, N=16, MIN_BIN=1, half spectrum).
// The stimulus pushes expected amp / peak / frame_err events with their cycle;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_fft_peak_tracker;

    localparam int DW        = 12;
    localparam int N_LOG2    = 4;
    localparam int MIN_BIN   = 1;
    localparam int HALF_SPEC = 1;
    localparam int FCNT_W    = 16;
    localparam int N         = 16;

    logic                 sys_clk   = 1'b0;
    logic                 sys_rst   = 1'b0;
    logic                 src_valid = 1'b0;
    logic                 src_sop   = 1'b0;
    logic                 src_eop   = 1'b0;
    logic signed [DW-1:0] src_real  = '0;
    logic signed [DW-1:0] src_imag  = '0;
    logic                 amp_valid;
    logic [2*DW-1:0]      amp_data;
    logic [N_LOG2-1:0]    amp_bin;
    logic                 peak_valid;
    logic [N_LOG2-1:0]    peak_bin;
    logic [2*DW-1:0]      peak_amp;
    logic                 frame_err;
    logic [FCNT_W-1:0]    frame_cnt;

    fft_peak_tracker #(
        .DW(DW), .N_LOG2(N_LOG2), .MIN_BIN(MIN_BIN), .HALF_SPEC(HALF_SPEC), .FCNT_W(FCNT_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag),
        .amp_valid(amp_valid), .amp_data(amp_data), .amp_bin(amp_bin),
        .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_amp(peak_amp),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int     cyc;
        int     bin;
        longint val;
        int     cnt;
    } exp_t;

    exp_t amp_q[$];
    exp_t peak_q[$];
    exp_t err_q[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int fr_re[N];
    int fr_im[N];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag_error(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: pop and compare whenever the DUT presents an event; flag overdue expectations
    always @(negedge sys_clk) begin : monitor
        exp_t e;
        if (amp_valid === 1'b1) begin
            if (amp_q.size() == 0) begin
                flag_error($sformatf("amp_unexpected bin %0d data %0d, required none", amp_bin, amp_data));
            end else begin
                e = amp_q.pop_front();
                check("amp_cycle", 64'(cyc), 64'(e.cyc));
                check("amp_bin", 64'(amp_bin), 64'(e.bin));
                check("amp_data", 64'(amp_data), 64'(e.val));
            end
        end
        while (amp_q.size() > 0 && amp_q[0].cyc < cyc) begin
            e = amp_q.pop_front();
            flag_error($sformatf("amp_missing bin %0d due cycle %0d", e.bin, e.cyc));
        end
        if (peak_valid === 1'b1) begin
            if (peak_q.size() == 0) begin
                flag_error($sformatf("peak_unexpected bin %0d amp %0d, required none", peak_bin, peak_amp));
            end else begin
                e = peak_q.pop_front();
                check("peak_cycle", 64'(cyc), 64'(e.cyc));
                check("peak_bin", 64'(peak_bin), 64'(e.bin));
                check("peak_amp", 64'(peak_amp), 64'(e.val));
                check("frame_cnt_at_peak", 64'(frame_cnt), 64'(e.cnt));
            end
        end
        while (peak_q.size() > 0 && peak_q[0].cyc < cyc) begin
            e = peak_q.pop_front();
            flag_error($sformatf("peak_missing due cycle %0d", e.cyc));
        end
        if (frame_err === 1'b1) begin
            if (err_q.size() == 0) begin
                flag_error("frame_err_unexpected, required none");
            end else begin
                e = err_q.pop_front();
                check("frame_err_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
            e = err_q.pop_front();
            flag_error($sformatf("frame_err_missing due cycle %0d", e.cyc));
        end
    end

    task automatic drive(input logic v, input logic sop, input logic eop, input int re, input int im);
        @(negedge sys_clk);
        src_valid = v;
        src_sop   = sop;
        src_eop   = eop;
        src_real  = DW'(re);
        src_imag  = DW'(im);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    // Send nb beats of fr_re/fr_im, sop on beat 0, eop on beat eop_at (-1: none),
    // random idle gaps of 0..max_gap cycles between beats. Every beat produces an amp.
    task automatic send_frame(input int nb, input int eop_at, input int max_gap,
                              output int first_at, output int last_at);
        first_at = 0;
        last_at  = 0;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) idle(int'($urandom_range(max_gap, 0)));
            drive(1'b1, i == 0, i == eop_at, fr_re[i], fr_im[i]);
            if (i == 0) first_at = cyc;
            last_at = cyc;
            amp_q.push_back('{cyc + 2, i, longint'(fr_re[i] * fr_re[i] + fr_im[i] * fr_im[i]), 0});
        end
    endtask

    task automatic push_peak(input int eop_at, input int bin, input longint amp, input int cnt);
        peak_q.push_back('{eop_at + 3, bin, amp, cnt});
    endtask

    task automatic push_err(input int beat_at);
        err_q.push_back('{beat_at + 1, 0, 0, 0});
    endtask

    // Frame-level reference: largest |X|^2 over bins MIN_BIN..N/2-1, lowest bin on ties
    function automatic void model_peak(output int b, output longint a);
        longint m;
        b = MIN_BIN;
        a = 0;
        for (int i = MIN_BIN; i <= N / 2 - 1; i++) begin
            m = fr_re[i] * fr_re[i] + fr_im[i] * fr_im[i];
            if (m > a) begin
                a = m;
                b = i;
            end
        end
    endfunction

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int     f, l, pb;
        longint pa;

        // 1: reset held two cycles with random inputs
        repeat (2) begin
            @(negedge sys_clk);
            sys_rst   = 1'b1;
            src_valid = 1'($urandom);
            src_sop   = 1'($urandom);
            src_eop   = 1'($urandom);
            src_real  = DW'($urandom);
            src_imag  = DW'($urandom);
        end
        @(negedge sys_clk);
        check("rst_amp_valid", 64'(amp_valid), 64'(0));
        check("rst_amp_data", 64'(amp_data), 64'(0));
        check("rst_amp_bin", 64'(amp_bin), 64'(0));
        check("rst_peak_valid", 64'(peak_valid), 64'(0));
        check("rst_peak_bin", 64'(peak_bin), 64'(0));
        check("rst_peak_amp", 64'(peak_amp), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        sys_rst   = 1'b0;
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        src_real  = '0;
        src_imag  = '0;
        idle(2);

        // 2: single non-zero bin
        clear_frame();
        fr_re[3] = 100;
        fr_im[3] = -50;
        send_frame(16, 15, 0, f, l);
        push_peak(l, 3, 12500, 1);

        // 3a: extreme value on bin 2, equally large on ineligible bins 0 and 9
        clear_frame();
        fr_re[2] = -2048; fr_im[2] = -2048;
        fr_re[0] = -2048; fr_im[0] = -2048;
        fr_re[9] = -2048; fr_im[9] = -2048;
        send_frame(16, 15, 0, f, l);
        push_peak(l, 2, 8388608, 2);

        // 3b: big values only outside 1..7; top eligible bin 7 wins
        clear_frame();
        fr_re[5]  = 10;
        fr_re[7]  = 11;
        fr_re[0]  = 2047;  fr_im[0]  = 2047;
        fr_re[8]  = -2048; fr_im[8]  = -2048;
        fr_re[15] = -2048; fr_im[15] = 2047;
        send_frame(16, 15, 0, f, l);
        push_peak(l, 7, 121, 3);

        // 4: tie between bins 4 and 6
        clear_frame();
        fr_re[4] = 20;
        fr_im[6] = -20;
        send_frame(16, 15, 0, f, l);
        push_peak(l, 4, 400, 4);

        // all-zero frame: peak reported at MIN_BIN with zero amplitude
        clear_frame();
        send_frame(16, 15, 0, f, l);
        push_peak(l, 1, 0, 5);
        idle(5);

        // 5a: eop at bin 10
        clear_frame();
        fr_re[3] = 50;
        send_frame(11, 10, 0, f, l);
        push_err(l);
        idle(6);
        check("cnt_after_short_frame", 64'(frame_cnt), 64'(5));
        check("peak_held_after_err", 64'(peak_bin), 64'(1));

        // 5b: sop at bin 5 aborts, then a full frame from that sop
        clear_frame();
        fr_re[2] = 1000;
        send_frame(5, -1, 0, f, l);
        push_err(l + 1);
        clear_frame();
        fr_re[1] = 3;
        fr_re[6] = -7;
        send_frame(16, 15, 0, f, l);
        push_peak(l, 6, 49, 6);
        idle(5);

        // 5c: bin N-1 without eop, then beats without sop are dropped
        clear_frame();
        fr_im[2] = 5;
        send_frame(16, -1, 0, f, l);
        push_err(l);
        drive(1'b1, 1'b0, 1'b0, 9, 9);
        drive(1'b1, 1'b0, 1'b1, 9, 9);
        idle(6);
        check("cnt_after_overrun", 64'(frame_cnt), 64'(6));

        // 6: reset, three back-to-back frames with random gaps and data
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("cnt_after_reset", 64'(frame_cnt), 64'(0));
        check("peak_amp_after_reset", 64'(peak_amp), 64'(0));
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = int'($urandom_range(4095, 0)) - 2048;
                fr_im[i] = int'($urandom_range(4095, 0)) - 2048;
            end
            send_frame(16, 15, 2, f, l);
            model_peak(pb, pa);
            push_peak(l, pb, pa, k + 1);
        end
        idle(5);
        check("cnt_after_three", 64'(frame_cnt), 64'(3));

        // reset in the middle of a frame discards it and returns the FSM to IDLE
        clear_frame();
        fr_re[4] = 77;
        send_frame(5, -1, 1, f, l);
        idle(4);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("cnt_after_midframe_reset", 64'(frame_cnt), 64'(0));
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 30, 30);
        drive(1'b1, 1'b0, 1'b0, 30, 30);
        drive(1'b1, 1'b0, 1'b1, 30, 30);
        idle(4);
        clear_frame();
        fr_re[7] = -1;
        send_frame(16, 15, 0, f, l);
        push_peak(l, 7, 1, 1);
        idle(6);

        check("amp_queue_drained", 64'(amp_q.size()), 64'(0));
        check("peak_queue_drained", 64'(peak_q.size()), 64'(0));
        check("err_queue_drained", 64'(err_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
